// File: rtl/elbeth_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states,
// the latched request record and small lane/check helpers.
package elbeth_dmem_responder_pkg;

   localparam logic [3:0] SIZE_BYTE = 4'b0001;
   localparam logic [3:0] SIZE_HALF = 4'b0011;
   localparam logic [3:0] SIZE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_RESP = 2'b10
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  size;
      logic [31:0] wdata;
      logic        err;
   } req_t;

   function automatic logic size_valid(input logic [3:0] size);
      return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
   endfunction

   function automatic logic aligned(input logic [3:0] size, input logic [1:0] lane);
      return !((size == SIZE_HALF && lane[0]) || (size == SIZE_WORD && lane != 2'b00));
   endfunction

   // Expands the per-byte size mask into a 32-bit data mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] size);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{size[i]}};
      return m;
   endfunction

endpackage

// File: rtl/elbeth_sram_1rw.sv
// Single-port word SRAM: synchronous read, per-byte write enables, no reset.
module elbeth_sram_1rw #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: the array has no reset branch; clearing it would turn the RAM into
   // a huge register file, and software must not rely on its power-up contents.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/elbeth_dmem_responder.sv
// Memory-side responder for the core's dmem_* port group: request checks,
// programmable wait states, byte-lane mapping and a one-cycle ready/error strobe.
module elbeth_dmem_responder #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic        mem_en,
   input  logic        mem_wr,
   input  logic [3:0]  mem_data_size,
   input  logic [31:0] mem_w_data,
   output logic [31:0] mem_r_data,
   output logic        mem_ready,
   output logic        mem_error
);

   import elbeth_dmem_responder_pkg::*;

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t      state, state_nx;
   req_t        req_q;
   logic [3:0]  cnt_q;
   logic [31:0] hold_q;

   logic [31:0] cur_addr, cur_wdata, addr_off;
   logic [3:0]  cur_size;
   logic        cur_wr, cur_err, in_range;
   logic [1:0]  lane;
   logic        access;

   logic          sram_en;
   logic [3:0]    sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata, sram_rdata;
   logic [31:0]   resp_data;

   // The SRAM is accessed on the edge that enters RESP. With no wait states
   // that edge is the acceptance edge, so IDLE must look at the live inputs.
   always_comb begin
      if (state == S_IDLE) begin
         cur_addr  = mem_addr;
         cur_wr    = mem_wr;
         cur_size  = mem_data_size;
         cur_wdata = mem_w_data;
      end else begin
         cur_addr  = req_q.addr;
         cur_wr    = req_q.wr;
         cur_size  = req_q.size;
         cur_wdata = req_q.wdata;
      end
      addr_off = cur_addr - BASE_ADDR;
      lane     = addr_off[1:0];
      in_range = (cur_addr >= BASE_ADDR) && ({1'b0, addr_off} < SPAN);
      cur_err  = !size_valid(cur_size) || !aligned(cur_size, lane) || !in_range;
   end

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      access   = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_en) begin
               state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               access   = (WAIT_STATES == 0);
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_nx = S_RESP;
               access   = 1'b1;
            end
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Gating with rst keeps an aborted write out of the array even when the
   // reset lands on the commit edge.
   always_comb begin
      sram_en    = access && !cur_err && !rst;
      sram_we    = cur_wr ? (cur_size << lane) : 4'b0000;
      sram_addr  = addr_off[AW+1:2];
      sram_wdata = cur_wdata << {lane, 3'b000};
   end

   elbeth_sram_1rw #(.DEPTH(DEPTH)) u_sram (
      .clk   (clk),
      .en    (sram_en),
      .we    (sram_we),
      .addr  (sram_addr),
      .wdata (sram_wdata),
      .rdata (sram_rdata)
   );

   always_comb begin
      if (req_q.err || req_q.wr) resp_data = 32'h0;
      else resp_data = (sram_rdata >> {req_q.addr[1:0], 3'b000}) & byte_mask(req_q.size);
   end

   assign mem_ready  = (state == S_RESP);
   assign mem_error  = mem_ready && req_q.err;
   assign mem_r_data = mem_ready ? resp_data : hold_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt_q  <= 4'd0;
         hold_q <= 32'h0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && mem_en) cnt_q <= WAIT_LOAD;
         else if (state == S_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
         if (state == S_RESP) hold_q <= resp_data;
      end
   end

   // Request record is pure datapath; it is only consumed after a fresh capture.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && mem_en) begin
         req_q.addr  <= mem_addr;
         req_q.wr    <= mem_wr;
         req_q.size  <= mem_data_size;
         req_q.wdata <= mem_w_data;
         req_q.err   <= cur_err;
      end
   end

endmodule
